// File: rtl/sm_board_ctrl.sv
// Board I/O and debug controller for the schoolRISCV core: synchronises switches and keys,
// debounces keys, provides single-step and core reset, and runs a memory-mapped display/LED block.
module sm_board_ctrl #(
  parameter int          DIGITS     = 6,
  parameter int          LEDS       = 10,
  parameter int          SW_W       = 10,
  parameter int          DEB_CYCLES = 500000,
  parameter logic [31:0] IO_BASE    = 32'h0000_0080
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SW_W-1:0]       sw,
  input  logic [1:0]            key,
  input  logic [31:0]           dbgData,
  input  logic                  dbgLed,
  input  logic [31:0]           busAddr,
  input  logic [31:0]           busWdata,
  input  logic                  busWe,
  output logic [31:0]           busRdata,
  output logic                  coreRst_n,
  output logic                  clkEnable,
  output logic [8*DIGITS-1:0]   hex,
  output logic [LEDS-1:0]       leds
);

  localparam int             CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  localparam logic [2:0] REG_LED    = 3'd0;
  localparam logic [2:0] REG_RAW0   = 3'd1;
  localparam logic [2:0] REG_RAW1   = 3'd2;
  localparam logic [2:0] REG_VAL    = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  // Input synchronisers, debounce and step pulse
  logic [SW_W-1:0]             sw_meta, sw_sync;
  logic [1:0]                  key_meta, key_sync, key_deb, key_flip;
  logic [1:0][CNT_W-1:0]       deb_cnt;
  logic                        step_pulse;
  logic                        dbg_mode, run;

  assign dbg_mode = sw_sync[SW_W-1];
  assign run      = sw_sync[SW_W-2];

  always_comb begin
    for (int k = 0; k < 2; k++)
      key_flip[k] = (key_sync[k] != key_deb[k]) && (deb_cnt[k] == DEB_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_meta    <= '1;
      sw_sync    <= '1;
      key_meta   <= 2'b11;
      key_sync   <= 2'b11;
      key_deb    <= 2'b11;
      deb_cnt    <= '0;
      step_pulse <= 1'b0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      key_meta <= key;
      key_sync <= key_meta;
      for (int k = 0; k < 2; k++) begin
        if (key_sync[k] == key_deb[k]) begin
          deb_cnt[k] <= '0;
        end else if (key_flip[k]) begin
          key_deb[k] <= key_sync[k];
          deb_cnt[k] <= '0;
        end else begin
          deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end
      end
      // Fires on the edge where the debounced step key falls, so holding it yields one pulse
      step_pulse <= key_flip[1] & key_deb[1];
    end
  end

  assign clkEnable = dbg_mode ? (run | step_pulse) : 1'b1;
  assign coreRst_n = dbg_mode ? key_deb[0] : 1'b1;

  // Register window
  logic [31:0] offset;
  logic        in_win;
  logic [2:0]  reg_idx;
  logic [31:0] led_reg, hex_raw0, hex_raw1, hex_val;
  logic        ctrl_dec;
  logic [7:0]  ctrl_blank;
  logic [31:0] rd_val;

  assign offset  = busAddr - IO_BASE;
  assign in_win  = (offset[31:5] == '0);
  assign reg_idx = offset[4:2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_reg    <= '0;
      hex_raw0   <= '1;
      hex_raw1   <= '1;
      hex_val    <= '0;
      ctrl_dec   <= 1'b0;
      ctrl_blank <= '0;
    end else if (busWe && in_win) begin
      case (reg_idx)
        REG_LED:  led_reg  <= busWdata;
        REG_RAW0: hex_raw0 <= busWdata;
        REG_RAW1: hex_raw1 <= busWdata;
        REG_VAL:  hex_val  <= busWdata;
        REG_CTRL: begin
          ctrl_dec   <= busWdata[0];
          ctrl_blank <= busWdata[15:8];
        end
        default: ;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_val = '0;
    case (reg_idx)
      REG_LED:    rd_val = led_reg;
      REG_RAW0:   rd_val = hex_raw0;
      REG_RAW1:   rd_val = hex_raw1;
      REG_VAL:    rd_val = hex_val;
      REG_CTRL:   rd_val = {16'h0, ctrl_blank, 7'h0, ctrl_dec};
      REG_STATUS: rd_val = 32'({key_deb, sw_sync});
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busRdata <= '0;
    else        busRdata <= in_win ? rd_val : '0;
  end

  // Display mux
  logic [63:0] hex_raw_all;
  assign hex_raw_all = {hex_raw1, hex_raw0};

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign hex[8*i +: 8] = dbg_mode      ? {1'b1, seg_decode(dbgData[4*i +: 4])} :
                           ctrl_blank[i] ? 8'hFF :
                           ctrl_dec      ? {1'b1, seg_decode(hex_val[4*i +: 4])} :
                                           hex_raw_all[8*i +: 8];
  end

  always_comb begin
    leds    = led_reg[LEDS-1:0];
    leds[0] = dbg_mode ? dbgLed : led_reg[0];
  end

  logic unused_bits;
  assign unused_bits = ^{dbgData, offset[1:0]};

endmodule

// File: tb/tb_sm_board_ctrl.sv
// Directed bench for sm_board_ctrl: reset, bus window, display modes, debounce/step and core reset.
module tb_sm_board_ctrl;

  localparam logic [31:0] BASE = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  sw;
  logic [1:0]  key;
  logic [31:0] dbgData;
  logic        dbgLed;
  logic [31:0] busAddr, busWdata, busRdata;
  logic        busWe;
  logic        coreRst_n, clkEnable;
  logic [47:0] hex;
  logic [9:0]  leds;

  int n_cmp = 0;
  int n_bad = 0;

  sm_board_ctrl #(
    .DIGITS(6), .LEDS(10), .SW_W(10), .DEB_CYCLES(4), .IO_BASE(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .key(key), .dbgData(dbgData), .dbgLed(dbgLed),
    .busAddr(busAddr), .busWdata(busWdata), .busWe(busWe), .busRdata(busRdata),
    .coreRst_n(coreRst_n), .clkEnable(clkEnable), .hex(hex), .leds(leds)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    busAddr  = addr;
    busWdata = data;
    busWe    = 1'b1;
    cycles(1);
    busWe    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    busAddr = addr;
    busWe   = 1'b0;
    cycles(1);
    data = busRdata;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sw = 10'h000; key = 2'b11; dbgData = 32'h0; dbgLed = 1'b0;
    busAddr = 32'h0; busWdata = 32'h0; busWe = 1'b0;
    cycles(3);
    n_cmp++; if (busRdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got=%h exp=%h", busRdata, 32'h0); end
    n_cmp++; if (leds !== 10'h0) begin n_bad++; $display("FAIL rst_leds_in_reset got=%h exp=%h", leds, 10'h0); end
    rst_n = 1'b1;
    cycles(3);
    n_cmp++; if (hex !== {6{8'hFF}}) begin n_bad++; $display("FAIL rst_hex got=%h exp=%h", hex, {6{8'hFF}}); end
    n_cmp++; if (leds !== 10'h0) begin n_bad++; $display("FAIL rst_leds got=%h exp=%h", leds, 10'h0); end
    n_cmp++; if (clkEnable !== 1'b1) begin n_bad++; $display("FAIL rst_clken got=%b exp=1", clkEnable); end
    n_cmp++; if (coreRst_n !== 1'b1) begin n_bad++; $display("FAIL rst_corerst got=%b exp=1", coreRst_n); end
    n_cmp++; if (busRdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata_after got=%h exp=%h", busRdata, 32'h0); end
  endtask

  task automatic test_bus;
    logic [31:0] rd;
    busAddr = BASE; busWdata = 32'h3FF; busWe = 1'b1;
    cycles(1);
    n_cmp++; if (busRdata !== 32'h0) begin n_bad++; $display("FAIL bus_prewrite got=%h exp=%h", busRdata, 32'h0); end
    busWe = 1'b0;
    cycles(1);
    n_cmp++; if (busRdata !== 32'h3FF) begin n_bad++; $display("FAIL bus_postwrite got=%h exp=%h", busRdata, 32'h3FF); end
    n_cmp++; if (leds !== 10'h3FF) begin n_bad++; $display("FAIL bus_leds got=%h exp=%h", leds, 10'h3FF); end
    bus_write(BASE + 32'h40, 32'h55);
    bus_read(BASE + 32'h40, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL bus_outside_read got=%h exp=%h", rd, 32'h0); end
    bus_read(BASE + 32'h2, rd);
    n_cmp++; if (rd !== 32'h3FF) begin n_bad++; $display("FAIL bus_outside_nowrite got=%h exp=%h", rd, 32'h3FF); end
    bus_write(BASE + 32'h18, 32'hDEAD);
    bus_read(BASE + 32'h18, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL bus_reserved got=%h exp=%h", rd, 32'h0); end
    bus_write(BASE + 32'h20, 32'h1);
    bus_read(BASE + 32'h10, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL bus_past_end got=%h exp=%h", rd, 32'h0); end
    sw = 10'h0A5;
    cycles(3);
    bus_read(BASE + 32'h14, rd);
    n_cmp++; if (rd !== 32'h0000_0CA5) begin n_bad++; $display("FAIL bus_status got=%h exp=%h", rd, 32'h0000_0CA5); end
    sw = 10'h000;
    cycles(3);
  endtask

  task automatic test_hex;
    logic [31:0] rd;
    bus_write(BASE + 32'h4, 32'h1234_5678);
    bus_write(BASE + 32'h8, 32'h0000_AABB);
    cycles(1);
    n_cmp++; if (hex !== 48'hAABB_1234_5678) begin n_bad++; $display("FAIL hex_raw got=%h exp=%h", hex, 48'hAABB_1234_5678); end
    bus_read(BASE + 32'h8, rd);
    n_cmp++; if (rd !== 32'h0000_AABB) begin n_bad++; $display("FAIL hex_raw1_read got=%h exp=%h", rd, 32'h0000_AABB); end
    bus_write(BASE + 32'hC, 32'h0012_3456);
    bus_write(BASE + 32'h10, 32'h1);
    cycles(1);
    n_cmp++; if (hex !== 48'hF9A4_B099_9282) begin n_bad++; $display("FAIL hex_dec got=%h exp=%h", hex, 48'hF9A4_B099_9282); end
    bus_write(BASE + 32'h10, 32'h0000_0301);
    cycles(1);
    n_cmp++; if (hex !== 48'hF9A4_B099_FFFF) begin n_bad++; $display("FAIL hex_blank got=%h exp=%h", hex, 48'hF9A4_B099_FFFF); end
    bus_read(BASE + 32'h10, rd);
    n_cmp++; if (rd !== 32'h0000_0301) begin n_bad++; $display("FAIL hex_ctrl_read got=%h exp=%h", rd, 32'h0000_0301); end
  endtask

  task automatic test_dbg_display;
    sw = 10'h200; dbgData = 32'h00AB_CDEF; dbgLed = 1'b1;
    cycles(3);
    n_cmp++; if (hex !== 48'h8883_C6A1_868E) begin n_bad++; $display("FAIL dbg_hex got=%h exp=%h", hex, 48'h8883_C6A1_868E); end
    n_cmp++; if (leds !== 10'h3FF) begin n_bad++; $display("FAIL dbg_led_hi got=%h exp=%h", leds, 10'h3FF); end
    dbgLed = 1'b0;
    cycles(1);
    n_cmp++; if (leds !== 10'h3FE) begin n_bad++; $display("FAIL dbg_led_lo got=%h exp=%h", leds, 10'h3FE); end
  endtask

  task automatic test_step;
    int pulses;
    int first;
    sw = 10'h200; key = 2'b11;
    cycles(3);
    n_cmp++; if (clkEnable !== 1'b0) begin n_bad++; $display("FAIL step_idle got=%b exp=0", clkEnable); end
    key = 2'b01;
    cycles(2);
    key = 2'b11;
    pulses = 0;
    repeat (12) begin cycles(1); if (clkEnable) pulses++; end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL step_glitch got=%0d exp=0", pulses); end
    key = 2'b01;
    pulses = 0; first = -1;
    for (int c = 1; c <= 10; c++) begin
      cycles(1);
      if (clkEnable) begin pulses++; if (first < 0) first = c; end
    end
    key = 2'b11;
    repeat (12) begin cycles(1); if (clkEnable) pulses++; end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL step_count got=%0d exp=1", pulses); end
    n_cmp++; if (first < 5 || first > 6) begin n_bad++; $display("FAIL step_latency got=%0d exp=5..6", first); end
    sw = 10'h300;
    cycles(3);
    n_cmp++; if (clkEnable !== 1'b1) begin n_bad++; $display("FAIL step_run got=%b exp=1", clkEnable); end
  endtask

  task automatic test_core_reset;
    sw = 10'h200; key = 2'b10;
    cycles(4);
    n_cmp++; if (coreRst_n !== 1'b1) begin n_bad++; $display("FAIL crst_early got=%b exp=1", coreRst_n); end
    cycles(4);
    n_cmp++; if (coreRst_n !== 1'b0) begin n_bad++; $display("FAIL crst_held got=%b exp=0", coreRst_n); end
    sw = 10'h000;
    cycles(1);
    n_cmp++; if (coreRst_n !== 1'b0) begin n_bad++; $display("FAIL crst_sync1 got=%b exp=0", coreRst_n); end
    cycles(1);
    n_cmp++; if (coreRst_n !== 1'b1) begin n_bad++; $display("FAIL crst_sync2 got=%b exp=1", coreRst_n); end
    key = 2'b11;
    cycles(8);
  endtask

  task automatic test_reset_precedence;
    busAddr = BASE; busWdata = 32'h123; busWe = 1'b1; rst_n = 1'b0;
    cycles(1);
    busWe = 1'b0; rst_n = 1'b1;
    cycles(1);
    n_cmp++; if (busRdata !== 32'h0) begin n_bad++; $display("FAIL rstwe_rdata got=%h exp=%h", busRdata, 32'h0); end
    n_cmp++; if (leds !== 10'h0) begin n_bad++; $display("FAIL rstwe_leds got=%h exp=%h", leds, 10'h0); end
  endtask

  initial begin
    test_reset();
    test_bus();
    test_hex();
    test_dbg_display();
    test_step();
    test_core_reset();
    test_reset_precedence();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
